ram8_scan: RTL and testbench

RAM8_SCAN -- requirements
Module: ram8_scan

---
 rtl/ram8_scan.sv | 95 +++++++++
 tb/tb_ram8_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram8_scan.sv
// ram8_scan: 8 x 16-bit register file with a read port and a write port.
// A background scan streams all eight words out, one per cycle.
module ram8_scan (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  output logic [15:0] out,
  input  logic        dump_start,
  output logic        dump_busy,
  output logic        dump_valid,
  output logic [2:0]  dump_addr,
  output logic [15:0] dump_data,
  output logic        dump_done
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  state_e      state_q;
  logic [2:0]  ptr_q;
  logic [2:0]  ptr_d;
  logic [15:0] mem_q [8];
  logic [7:0]  we_d;
  logic        busy_q;
  logic        valid_q;
  logic        done_q;
  logic [2:0]  addr_q;
  logic [15:0] data_q;

  // One-hot write strobe: load steered to the addressed word
  always_comb begin
    we_d = '0;
    if (load) we_d[address] = 1'b1;
  end

  // Register file; cleared asynchronously by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (we_d[i]) mem_q[i] <= in;
    end
  end

  assign out   = mem_q[address];
  assign ptr_d = ptr_q + 3'd1;

  // Scan FSM: captures pre-edge word at ptr each SCAN cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (dump_start) begin
            state_q <= SCAN;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          valid_q <= 1'b1;
          addr_q  <= ptr_q;
          data_q  <= mem_q[ptr_q];
          ptr_q   <= ptr_d;
          if (ptr_q == 3'd7) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign dump_busy  = busy_q;
  assign dump_valid = valid_q;
  assign dump_done  = done_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_ram8_scan.sv
// tb_ram8_scan: directed stimulus with an edge-count model of the scan
// and a per-cycle compare, plus literal spot checks.
module tb_ram8_scan;

  logic        clock;
  logic        reset_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;
  logic        dump_start;
  logic        dump_busy;
  logic        dump_valid;
  logic [2:0]  dump_addr;
  logic [15:0] dump_data;
  logic        dump_done;

  int checks = 0;
  int failures = 0;

  ram8_scan dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in         (in),
    .load       (load),
    .address    (address),
    .out        (out),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a scan accepted at edge s yields word (e-s-1) at edges
  // s+1..s+8; busy spans edges s..s+7. Capture uses pre-edge contents.
  logic [15:0] m_mem [8] = '{default: 16'h0};
  int          m_edge = 0;
  int          m_s = -100;
  logic        e_valid = 0;
  logic        e_done = 0;
  logic        e_busy = 0;
  logic [2:0]  e_addr = 0;
  logic [15:0] e_data = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
      m_edge  = 0;
      m_s     = -100;
      e_valid = 0;
      e_done  = 0;
      e_busy  = 0;
      e_addr  = 0;
      e_data  = 0;
    end else begin
      int a;
      bit scanning;
      m_edge++;
      scanning = (m_edge >= m_s + 1) && (m_edge <= m_s + 8);
      if (scanning) begin
        a       = m_edge - m_s - 1;
        e_valid = 1;
        e_addr  = 3'(a);
        e_data  = m_mem[a];
        e_done  = (a == 7);
      end else begin
        e_valid = 0;
        e_done  = 0;
      end
      if (!scanning && dump_start) m_s = m_edge;
      e_busy = (m_edge >= m_s) && (m_edge <= m_s + 7);
      if (load) m_mem[address] = in;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("cyc_out",   32'(out),        32'(m_mem[address]));
      chk("cyc_valid", 32'(dump_valid), 32'(e_valid));
      chk("cyc_done",  32'(dump_done),  32'(e_done));
      chk("cyc_busy",  32'(dump_busy),  32'(e_busy));
      chk("cyc_addr",  32'(dump_addr),  32'(e_addr));
      chk("cyc_data",  32'(dump_data),  32'(e_data));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!dump_busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  // Start at posedge+2; ends on the negedge after the done cycle
  task automatic run_scan_lit(input logic [15:0] exp [8]);
    dump_start = 1;
    tick();
    dump_start = 0;
    @(negedge clock);
    chk("lit_busy_rise", 32'(dump_busy), 32'd1);
    chk("lit_pre_valid", 32'(dump_valid), 32'd0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      chk("lit_valid", 32'(dump_valid), 32'd1);
      chk("lit_addr",  32'(dump_addr),  32'(j));
      chk("lit_data",  32'(dump_data),  32'(exp[j]));
      chk("lit_done",  32'(dump_done),  32'(j == 7));
      chk("lit_busy",  32'(dump_busy),  32'(j != 7));
    end
    @(negedge clock);
    chk("lit_post_valid", 32'(dump_valid), 32'd0);
    chk("lit_post_done",  32'(dump_done),  32'd0);
  endtask

  initial begin
    int nvalid;
    int ngap;
    int nexp;
    reset_n    = 0;
    in         = 0;
    load       = 0;
    address    = 0;
    dump_start = 0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1;
    @(negedge clock);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_busy",  32'(dump_busy),  32'd0);
    chk("rst_done",  32'(dump_done),  32'd0);
    chk("rst_addr",  32'(dump_addr),  32'd0);
    chk("rst_data",  32'(dump_data),  32'd0);
    chk("rst_out",   32'(out),        32'd0);
    tick();

    for (int i = 0; i < 8; i++) begin
      load    = 1;
      address = 3'(i);
      in      = 16'(i);
      tick();
    end
    load = 0;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      chk("wr_rd_out", 32'(out), 32'(i));
    end
    tick();

    run_scan_lit('{16'h0, 16'h1, 16'h2, 16'h3,
                   16'h4, 16'h5, 16'h6, 16'h7});
    tick();

    dump_start = 1;
    tick();
    dump_start = 0;
    tick();
    tick();
    tick();
    load    = 1;
    address = 3'd3;
    in      = 16'hBEEF;
    tick();
    load = 0;
    @(negedge clock);
    chk("coll_addr", 32'(dump_addr), 32'd3);
    chk("coll_data", 32'(dump_data), 32'h0003);
    wait_idle();
    tick();
    run_scan_lit('{16'h0, 16'h1, 16'h2, 16'hBEEF,
                   16'h4, 16'h5, 16'h6, 16'h7});
    tick();

    nvalid = 0;
    ngap   = 0;
    nexp   = 0;
    dump_start = 1;
    @(posedge clock);
    for (int i = 0; i < 27; i++) begin
      @(negedge clock);
      if (dump_valid) begin
        chk("b2b_addr", 32'(dump_addr), 32'(nexp));
        nexp = (nexp + 1) % 8;
        nvalid++;
      end else begin
        ngap++;
      end
    end
    dump_start = 0;
    chk("b2b_nvalid", 32'(nvalid), 32'd24);
    chk("b2b_ngap",   32'(ngap),   32'd3);
    wait_idle();
    tick();

    dump_start = 1;
    tick();
    dump_start = 0;
    repeat (5) tick();
    #1 reset_n = 0;
    #1;
    chk("arst_valid", 32'(dump_valid), 32'd0);
    chk("arst_busy",  32'(dump_busy),  32'd0);
    chk("arst_done",  32'(dump_done),  32'd0);
    chk("arst_addr",  32'(dump_addr),  32'd0);
    chk("arst_data",  32'(dump_data),  32'd0);
    dump_start = 1;
    load       = 1;
    in         = 16'h1234;
    tick();
    tick();
    dump_start = 0;
    load       = 0;
    reset_n    = 1;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      chk("arst_mem", 32'(out), 32'd0);
    end
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (dump_valid) nvalid++;
    end
    chk("arst_quiet", 32'(nvalid), 32'd0);
    tick();
    run_scan_lit('{default: 16'h0});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
